// File: rtl/alu_result_stage.sv
// ALU result stage: a 2-entry FIFO that buffers ALU results and status.
// Each entry's status commits into the architectural flag register
// (and the sticky overflow bit) only when the entry is popped.
module alu_result_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_status,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_status,
    output logic [3:0]       flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [1:0]       count
);

    // Status bit positions shared with the ALU (N, Z, C, V from MSB to LSB)
    localparam int ST_NEG      = 3;
    localparam int ST_ZERO     = 2;
    localparam int ST_CARRY    = 1;
    localparam int ST_OVERFLOW = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic             head_we;
    logic [WIDTH-1:0] tail_result;
    logic [3:0]       tail_status;
    logic             tail_we;
    logic             push;
    logic             pop;
    logic [3:0]       commit_flags;
    logic             set_sticky;

    // Handshakes depend only on registered state, so out_ready never reaches in_ready
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign count     = state;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flag value committed by the head entry, assembled field by field
    always_comb begin
        commit_flags               = '0;
        commit_flags[ST_NEG]       = out_status[ST_NEG];
        commit_flags[ST_ZERO]      = out_status[ST_ZERO];
        commit_flags[ST_CARRY]     = out_status[ST_CARRY];
        commit_flags[ST_OVERFLOW]  = out_status[ST_OVERFLOW];
    end

    assign set_sticky = pop && head_we && out_status[ST_OVERFLOW];

    // Occupancy state and head entry (head drives the registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_result <= '0;
            out_status <= '0;
            head_we    <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_result <= in_result;
                        out_status <= in_status;
                        head_we    <= in_flag_we;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Old head leaves, new entry takes its place directly
                        out_result <= in_result;
                        out_status <= in_status;
                        head_we    <= in_flag_we;
                    end else if (push) begin
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_result <= tail_result;
                        out_status <= tail_status;
                        head_we    <= tail_we;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Second slot, written only when a push lands behind an unpopped head
    always_ff @(posedge clk) begin
        if (state == ONE && push && !pop) begin
            tail_result <= in_result;
            tail_status <= in_status;
            tail_we     <= in_flag_we;
        end
    end

    // Architectural flags and sticky overflow, updated only on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= '0;
            sticky_ovf <= 1'b0;
        end else begin
            if (pop && head_we) begin
                flags <= commit_flags;
            end
            if (set_sticky) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_status;
    logic        in_flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_status;
    logic [3:0]  flags;
    logic        sticky_ovf;
    logic        clr_sticky;
    logic [1:0]  count;

    int checks;
    int errors;

    alu_result_stage #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_status  (in_status),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_status (out_status),
        .flags      (flags),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] s, input logic we);
        in_valid   = v;
        in_result  = r;
        in_status  = s;
        in_flag_we = we;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0);

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_flags", flags, 0);
        chk("rst_sticky", sticky_ovf, 0);
        rst_n = 1'b1;

        // Single op, accepted on first edge after reset release
        drive(1'b1, 16'h8001, 4'b1000, 1'b1);
        out_ready = 1'b1;
        step();
        chk("single_valid", out_valid, 1);
        chk("single_result", out_result, 16'h8001);
        chk("single_count", count, 1);
        chk("single_flags_before_pop", flags, 0);
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        chk("single_flags", flags, 4'b1000);
        chk("single_empty", count, 0);

        // Backpressure with third push held
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 4'b0000, 1'b0);
        step();
        drive(1'b1, 16'h0002, 4'b0000, 1'b0);
        step();
        drive(1'b1, 16'h0003, 4'b0000, 1'b0);
        chk("bp_count", count, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", out_result, 16'h0001);
        step();
        chk("bp_held_count", count, 2);
        chk("bp_stable", out_result, 16'h0001);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_result, 16'h0002);
        chk("bp_count_one", count, 1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("bp_third", out_result, 16'h0003);
        chk("bp_third_count", count, 1);
        step();
        chk("bp_drained", count, 0);
        chk("bp_flags_kept", flags, 4'b1000);

        // Simultaneous push and pop at count 1
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 4'b0000, 1'b0);
        step();
        chk("sim_head_aa", out_result, 16'h00AA);
        drive(1'b1, 16'h00BB, 4'b0000, 1'b0);
        out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("sim_count", count, 1);
        chk("sim_head_bb", out_result, 16'h00BB);
        step();
        chk("sim_empty", count, 0);

        // Sticky overflow
        drive(1'b1, 16'h0010, 4'b0001, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("stk_not_on_push", sticky_ovf, 0);
        step();
        chk("stk_set", sticky_ovf, 1);
        chk("stk_flags", flags, 4'b0001);
        drive(1'b1, 16'h0011, 4'b0000, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        chk("stk_hold", sticky_ovf, 1);
        chk("stk_flags_clear", flags, 4'b0000);
        drive(1'b1, 16'h0012, 4'b0001, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        clr_sticky = 1'b1;
        step();
        chk("stk_set_wins", sticky_ovf, 1);
        step();
        clr_sticky = 1'b0;
        chk("stk_cleared", sticky_ovf, 0);

        // flag_we=0 leaves flags alone
        drive(1'b1, 16'h0020, 4'b0100, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        step();
        chk("fwe_setup", flags, 4'b0100);
        drive(1'b1, 16'h0021, 4'b1001, 1'b0);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("fwe_status_passthru", out_status, 4'b1001);
        step();
        chk("fwe_flags", flags, 4'b0100);
        chk("fwe_sticky", sticky_ovf, 0);

        // Reset mid-run with FIFO full
        out_ready = 1'b0;
        drive(1'b1, 16'h0031, 4'b0001, 1'b1);
        step();
        drive(1'b1, 16'h0032, 4'b0001, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("mr_full", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_flags", flags, 0);
        chk("mr_result", out_result, 0);
        chk("mr_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mr_no_stale", out_valid, 0);
        chk("mr_sticky", sticky_ovf, 0);
        drive(1'b1, 16'h0055, 4'b0010, 1'b1);
        step();
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        chk("mr_new_result", out_result, 16'h0055);
        step();
        chk("mr_new_flags", flags, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL match the ALU WIDTH.
REQ-002 Status bit positions SHALL use the shared ALU include indices ST_NEG, ST_ZERO, ST_CARRY, ST_OVERFLOW throughout.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream ALU op result valid.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  WIDTH  ALU result.
REQ-008 in_status  input  4  ALU statusOut (N, Z, C, V).
REQ-009 in_flag_we  input  1  this op commits its status into the flag register.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_result  output  WIDTH  head entry result.
REQ-013 out_status  output  4  head entry status.
REQ-014 flags  output  4  architectural flag register (N, Z, C, V).
REQ-015 sticky_ovf  output  1  set by any committed overflow, held until cleared.
REQ-016 clr_sticky  input  1  synchronous clear of sticky_ovf.
REQ-017 count  output  2  current occupancy, 0..2.

Function
REQ-018 The stage SHALL be a 2-entry FIFO of {result, status, flag_we}, states EMPTY (count 0), ONE (1), FULL (2).
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (count != 2), registered-state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_result/out_status SHALL be the oldest entry, registered outputs.
REQ-022 Latency: an entry pushed at edge N SHALL be visible on out_* with out_valid=1 after edge N when the FIFO was EMPTY.
REQ-023 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop, with new entry at head after the edge; FULL->ONE on pop.
REQ-024 FULL with in_valid=1 SHALL not push, and the upstream holds data (in_ready=0).
REQ-025 out_result/out_status SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-027 On pop of an entry with flag_we=1, flags SHALL load that entry's status at the same edge; entries with flag_we=0 SHALL leave flags unchanged.
REQ-028 On pop of an entry with flag_we=1 and status[ST_OVERFLOW]=1, sticky_ovf SHALL set at that edge.
REQ-029 clr_sticky=1 SHALL clear sticky_ovf at the edge; a simultaneous set per REQ-028 SHALL win (sticky_ovf=1).
REQ-030 Pushes SHALL never affect flags or sticky_ovf; only pops commit.
REQ-031 The stage SHALL not modify result or status values.

Reset
REQ-032 While rst_n=0: count=0, out_valid=0, in_ready=1, out_result=0, out_status=0, flags=0, sticky_ovf=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately, with no pop or flag commit.
REQ-034 The first push SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-035 Single op: push result 0x8001 status N=1 flag_we=1, out_ready=1 -> out_valid next cycle, out_result 0x8001; after pop edge, flags=4'b1000 (N set).
REQ-036 Backpressure: out_ready=0, push 0x0001, 0x0002, 0x0003 -> count=2, in_ready=0, third held; release out_ready -> outputs 0x0001, 0x0002, 0x0003 in order.
REQ-037 Simultaneous: count=1 holding 0x00AA, push 0x00BB with pop -> count stays 1, out_result=0x00BB next cycle.
REQ-038 Sticky: pop an entry with V=1 flag_we=1 -> sticky_ovf=1; later V=0 pops keep it 1; clr_sticky with concurrent V=1 commit -> stays 1; clr_sticky alone -> 0.
REQ-039 flag_we=0: flags=4'b0100, pop entry with status 4'b1001 flag_we=0 -> flags stay 4'b0100, sticky_ovf unchanged.
REQ-040 Reset mid-run: count=2, assert rst_n=0 between edges -> out_valid=0, count=0, flags=0 immediately; no stale data after release.
